uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single board UART transmit line between two byte-stream requesters: port 0 is the CPU console and port 1 is the debug/status stream. Serializes the granted byte as 8N1 at a fixed baud divisor. Between frames it arbitrates round-robin. A line lock keeps one requester's text line contiguous until it sends an end-of-line byte or goes idle. It sits between the SoC UART/debug sources and the `uart_rxd_out` pin.

## Interface
- `BAUD_DIV`, default 868 — clock cycles per bit (100 MHz / 115200); legal range ≥ 2.
- `EOL_CHAR`, default 8'h0A — byte that releases the line lock after it is accepted.
- `LOCK_TIMEOUT`, default 65535 — idle cycles after which a held lock is dropped; legal range ≥ 1.

Ports:
- `CLK`  in  1 — single clock, rising edge.
- `RST_N`  in  1 — asynchronous, active-low reset.
- `req0_valid`  in  1 — requester 0 has a byte.
- `req0_data`  in  8 — requester 0 byte.
- `req0_ready`  out  1 — requester 0 byte accepted this cycle.
- `req1_valid`  in  1 — requester 1 has a byte.
- `req1_data`  in  8 — requester 1 byte.
- `req1_ready`  out  1 — requester 1 byte accepted this cycle.
- `uart_tx`  out  1 — serial line, idle high.
- `busy`  out  1 — frame in progress.
- `owner`  out  1 — requester currently granted or locked.
- `locked`  out  1 — line lock held by `owner`.

## Operation
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on accept.
  - START → DATA after `BAUD_DIV` cycles.
  - DATA → STOP after 8 bits.
  - STOP → IDLE after `BAUD_DIV` cycles.
- Selection `sel` (combinational, IDLE only):
  - If `locked`: `sel` = `owner`.
  - Else, if only one valid: `sel` = that one.
  - Else, if both valid: `sel` = `!last` (the requester not served last).
- `reqN_ready` = (state == IDLE) && `reqN_valid` && (`sel` == N). At most one ready per cycle.
- A byte is accepted when ready is high. Requesters hold valid/data stable until ready; valid must not depend on ready.
- On accept:
  - Latch data into the shift register.
  - Set `last` and `owner` to `sel`.
  - If data == `EOL_CHAR`, clear `locked`; otherwise set `locked` = 1.
- While `locked`, the non-owner gets no ready, even if the owner is idle.
- Timeout counter:
  - Cleared on every accept.
  - Increments while in IDLE && `locked` && owner not valid.
  - When the count reaches `LOCK_TIMEOUT`, `locked` clears that cycle and the counter clears.
- Serializer:
  - Start bit 0, then `data[0]` through `data[7]` LSB first, then stop bit 1.
  - Each bit lasts exactly `BAUD_DIV` cycles, timed by a bit-period down-counter and a 3-bit index.
- `uart_tx` is registered; no glitches.

## Timing
- Reset values: `uart_tx` = 1, `busy` = 0, `owner` = 0, `locked` = 0, `last` = 1 (requester 0 wins the first tie), state IDLE, all counters 0.
- `reqN_ready` is combinational in IDLE, so it may be high in the first cycle after reset release if valid is high.
- Accept at cycle T:
  - `uart_tx` falls and `busy` rises at T+1.
  - Data bit k occupies cycles T+1+(k+1)·`BAUD_DIV` … T+(k+2)·`BAUD_DIV`.
  - Stop bit ends at T+10·`BAUD_DIV`.
  - State is IDLE and `busy` = 0 at T+1+10·`BAUD_DIV`; the next accept is possible that same cycle.
- Back-to-back throughput: one byte per 10·`BAUD_DIV`+1 cycles.
- `owner` and `locked` update at T+1.
- Timeout fires exactly `LOCK_TIMEOUT` idle-qualifying cycles after the last accept or after the STOP → IDLE return, whichever is later.
- Reset asserted mid-frame: all state returns to reset values immediately (`uart_tx` = 1). The partial frame is abandoned, not resumed.
- Simultaneous valid with no lock: round-robin strictly alternates.

## Test plan
Sim parameters: `BAUD_DIV` = 4, `LOCK_TIMEOUT` = 20.

- Single byte: `req0` sends 8'hA5 at T. `req0_ready` is high at T. `uart_tx` is 0 for cycles T+1..T+4, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for T+37..T+40. `busy` is 0 at T+41.
- Lock and EOL: `req0` sends "H", "i", 8'h0A while `req1` holds 8'h55 valid throughout. `req1_ready` stays 0 until the 8'h0A frame completes, then `req1` is accepted in the first IDLE cycle; `locked` = 0 after the 8'h0A accept.
- Round-robin: both requesters are continuously valid with EOL bytes only. Accept order is 0, 1, 0, 1, and `owner` toggles at each accept+1.
- Timeout: `req0` sends 8'h41 (no EOL) then drops valid; `req1` is valid. `locked` clears 20 cycles after the return to IDLE, and `req1_ready` is high that cycle or the next.
- Reset mid-frame: assert `RST_N` = 0 during data bit 3. `uart_tx` = 1, `busy` = 0, `locked` = 0 asynchronously. After release, a `req1` byte transmits correctly.
- Back-to-back throughput: `req0` streams 4 bytes. Accepts are spaced exactly 41 cycles apart, with no idle high bit between a stop bit and the next start bit.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one UART transmit line between two byte requesters
//            (0 = CPU console, 1 = debug/status). Bytes are sent as 8N1 at a
//            fixed baud divisor. Between frames the requesters are served
//            round-robin; a line lock keeps one requester's text line
//            contiguous until it sends EOL_CHAR or stays idle for
//            LOCK_TIMEOUT cycles.
// Ports    : CLK, RST_N            - clock, asynchronous active-low reset
//            reqN_valid/data/ready - byte handshake for requester N (0,1)
//            uart_tx               - registered serial line, idle high
//            busy                  - frame in progress
//            owner                 - requester granted or holding the lock
//            locked                - line lock held by owner
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int          BAUD_DIV     = 868,
    parameter logic [7:0]  EOL_CHAR     = 8'h0A,
    parameter int          LOCK_TIMEOUT = 65535
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       uart_tx,
    output logic       busy,
    output logic       owner,
    output logic       locked
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    localparam logic [BW-1:0] C_BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] C_BAUD_ONE  = BW'(1);
    localparam logic [TW-1:0] C_TO_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] C_TO_ONE    = TW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          state_q;
    logic [7:0]      shift_q;
    logic [BW-1:0]   baud_q;
    logic [2:0]      idx_q;
    logic [TW-1:0]   to_cnt_q;
    logic            tx_q;
    logic            busy_q;
    logic            owner_q;
    logic            locked_q;
    logic            last_q;

    logic            w_idle;
    logic            w_sel;
    logic            w_accept;
    logic [7:0]      w_data;
    logic            w_owner_valid;

    assign w_idle = (state_q == S_IDLE);

    // Grant selection: the lock pins the owner; otherwise a lone requester
    // wins, and a tie goes to the requester not served last.
    always_comb begin
        w_sel = ~last_q;
        if (locked_q) begin
            w_sel = owner_q;
        end else if (req0_valid && !req1_valid) begin
            w_sel = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            w_sel = 1'b1;
        end
    end

    assign req0_ready    = w_idle && req0_valid && !w_sel;
    assign req1_ready    = w_idle && req1_valid &&  w_sel;
    assign w_accept      = req0_ready || req1_ready;
    assign w_data        = w_sel ? req1_data : req0_data;
    assign w_owner_valid = owner_q ? req1_valid : req0_valid;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            baud_q   <= '0;
            idx_q    <= '0;
            to_cnt_q <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            owner_q  <= 1'b0;
            locked_q <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        state_q  <= S_START;
                        shift_q  <= w_data;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        baud_q   <= C_BAUD_LAST;
                        owner_q  <= w_sel;
                        last_q   <= w_sel;
                        locked_q <= (w_data != EOL_CHAR);
                        to_cnt_q <= '0;
                    end else if (locked_q && !w_owner_valid) begin
                        // Owner idle while holding the line: drop the lock
                        // once LOCK_TIMEOUT such cycles have accumulated.
                        if (to_cnt_q == C_TO_LAST) begin
                            locked_q <= 1'b0;
                            to_cnt_q <= '0;
                        end else begin
                            to_cnt_q <= to_cnt_q + C_TO_ONE;
                        end
                    end
                end

                S_START: begin
                    if (baud_q == '0) begin
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        idx_q   <= 3'd0;
                        baud_q  <= C_BAUD_LAST;
                    end else begin
                        baud_q <= baud_q - C_BAUD_ONE;
                    end
                end

                S_DATA: begin
                    if (baud_q == '0) begin
                        baud_q <= C_BAUD_LAST;
                        if (idx_q == 3'd7) begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        baud_q <= baud_q - C_BAUD_ONE;
                    end
                end

                S_STOP: begin
                    if (baud_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        baud_q <= baud_q - C_BAUD_ONE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign uart_tx = tx_q;
    assign busy    = busy_q;
    assign owner   = owner_q;
    assign locked  = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter (BAUD_DIV=4,
//            LOCK_TIMEOUT=20). A frame-level model predicts every output
//            each cycle; directed scenarios add hand-computed checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int B   = 4;
    localparam int TO  = 20;
    localparam logic [7:0] EOL = 8'h0A;

    logic       CLK;
    logic       RST_N;
    logic       r0v, r1v;
    logic [7:0] r0d, r1d;
    logic       req0_ready, req1_ready;
    logic       uart_tx, busy, owner, locked;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    uart_tx_arbiter #(
        .BAUD_DIV     (B),
        .EOL_CHAR     (EOL),
        .LOCK_TIMEOUT (TO)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .req0_valid (r0v),
        .req0_data  (r0d),
        .req0_ready (req0_ready),
        .req1_valid (r1v),
        .req1_data  (r1d),
        .req1_ready (req1_ready),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .owner      (owner),
        .locked     (locked)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-level reference model: tracks the last accept cycle and byte,
    // derives the waveform arithmetically, and applies the grant rules.
    // ------------------------------------------------------------------
    int         m_T;
    logic [7:0] m_data;
    bit         m_owner, m_locked, m_last;
    int         m_cnt;

    initial begin
        int  c, k;
        bit  m_busy, s, e0, e1, etx, ov;
        m_T = -100000; m_data = 8'h00;
        m_owner = 0; m_locked = 0; m_last = 1; m_cnt = 0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                m_T = -100000; m_owner = 0; m_locked = 0; m_last = 1; m_cnt = 0;
            end
            c      = cyc;
            m_busy = (c >= m_T + 1) && (c <= m_T + 10 * B);
            etx    = 1'b1;
            if (m_busy) begin
                k = (c - m_T - 1) / B;
                if (k == 0)      etx = 1'b0;
                else if (k <= 8) etx = m_data[k-1];
                else             etx = 1'b1;
            end
            if (m_locked)        s = m_owner;
            else if (r0v && !r1v) s = 1'b0;
            else if (r1v && !r0v) s = 1'b1;
            else                 s = !m_last;
            e0 = !m_busy && r0v && (s == 1'b0);
            e1 = !m_busy && r1v && (s == 1'b1);

            chk("model_ready0", req0_ready, e0);
            chk("model_ready1", req1_ready, e1);
            chk("model_tx",     uart_tx,    etx);
            chk("model_busy",   busy,       m_busy);
            chk("model_owner",  owner,      m_owner);
            chk("model_locked", locked,     m_locked);

            if (RST_N) begin
                ov = m_owner ? r1v : r0v;
                if (e0 || e1) begin
                    m_T      = c;
                    m_data   = s ? r1d : r0d;
                    m_owner  = s;
                    m_last   = s;
                    m_locked = (m_data != EOL);
                    m_cnt    = 0;
                end else if (!m_busy && m_locked && !ov) begin
                    m_cnt++;
                    if (m_cnt == TO) begin
                        m_locked = 0;
                        m_cnt    = 0;
                    end
                end
            end
        end
    end

    // Present a byte on port p, wait (bounded) for ready, return accept cycle.
    // Must be called just after a rising edge.
    task automatic send(input int p, input logic [7:0] d, output int acc);
        int  waited;
        bit  got;
        waited = 0;
        got    = 0;
        acc    = -1;
        if (p == 0) begin r0v = 1'b1; r0d = d; end
        else        begin r1v = 1'b1; r1d = d; end
        while (!got && waited < 400) begin
            @(negedge CLK);
            if ((p == 0) ? req0_ready : req1_ready) begin
                got = 1;
                acc = cyc;
            end else begin
                waited++;
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout port %0d byte %02h: got no ready, expected ready", p, d);
        end
        @(posedge CLK);
        #1;
        if (p == 0) r0v = 1'b0;
        else        r1v = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        #2 RST_N = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #2 RST_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int a0, a1, a2, a3, b0, b1;
        logic [40:0] cap;
        logic [40:0] exp_a5;

        RST_N = 1'b0;
        r0v = 1'b0; r1v = 1'b0; r0d = 8'h00; r1d = 8'h00;

        // Reset state
        @(negedge CLK);
        chk("reset_tx",     uart_tx, 1);
        chk("reset_busy",   busy,    0);
        chk("reset_owner",  owner,   0);
        chk("reset_locked", locked,  0);
        #2 RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Single byte A5 with literal waveform: start, 1,0,1,0,0,1,0,1, stop, idle
        exp_a5 = {4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000,
                  4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 1'b1};
        send(0, 8'hA5, a0);
        for (int i = 0; i < 41; i++) begin
            @(negedge CLK);
            cap[40-i] = uart_tx;
            if (i == 0)  chk("a5_busy_T+1",  busy, 1);
            if (i == 40) chk("a5_busy_T+41", busy, 0);
        end
        chk("a5_waveform", cap, exp_a5);

        // Lock and EOL: req1 must wait for the whole "Hi\n" line
        apply_reset();
        fork
            begin
                int t;
                send(0, 8'h48, a0);
                send(0, 8'h69, t);
                send(0, EOL,   t);
            end
            send(1, 8'h55, b0);
        join
        chk("lock_req1_delay", b0 - a0, 123);

        // Round-robin with EOL-only bytes
        apply_reset();
        fork
            begin send(0, EOL, a0); send(0, EOL, a1); end
            begin send(1, EOL, b0); send(1, EOL, b1); end
        join
        chk("rr_second_is_1", b0 - a0, 41);
        chk("rr_third_is_0",  a1 - a0, 82);
        chk("rr_fourth_is_1", b1 - a0, 123);

        // Lock timeout: req0 sends a non-EOL byte then goes idle
        apply_reset();
        fork
            send(0, 8'h41, a0);
            send(1, 8'h77, b0);
        join
        chk("timeout_req1_delay", b0 - a0, 41 + TO);
        repeat (45) @(negedge CLK);

        // Reset during data bit 3 of 8'h35 (bit 3 = 0)
        apply_reset();
        send(0, 8'h35, a0);
        repeat (17) @(negedge CLK);
        chk("midreset_pre_tx",   uart_tx, 0);
        chk("midreset_pre_busy", busy,    1);
        #2 RST_N = 1'b0;
        #1;
        chk("midreset_tx",     uart_tx, 1);
        chk("midreset_busy",   busy,    0);
        chk("midreset_locked", locked,  0);
        @(negedge CLK);
        @(negedge CLK);
        #2 RST_N = 1'b1;
        @(posedge CLK);
        #1;
        send(1, 8'hC3, b0);
        repeat (41) @(negedge CLK);
        chk("post_reset_locked", locked, 1);
        chk("post_reset_owner",  owner,  1);
        @(posedge CLK);
        #1;

        // Back-to-back throughput
        apply_reset();
        send(0, 8'h01, a0);
        send(0, 8'h80, a1);
        send(0, 8'hFF, a2);
        send(0, 8'h00, a3);
        chk("b2b_gap1", a1 - a0, 41);
        chk("b2b_gap2", a2 - a1, 41);
        chk("b2b_gap3", a3 - a2, 41);
        repeat (45) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
